samp_seq: RTL and testbench
===========================

SAMP_SEQ -- requirements
Module: samp_seq

Interface
REQ-001 Parameter CNT_W, default 8, width of all timing-length inputs and internal phase counter.
REQ-002 Parameter NBITS, default 8, number of conversion bit cycles per sample; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sample/convert sequence.
REQ-006 abort  input  1  terminate the current sequence immediately.
REQ-007 samp_len  input  CNT_W  sampling phase length in cycles; 0 treated as 1.
REQ-008 hold_len  input  CNT_W  gap between sampling and conversion in cycles; 0 skips the gap.
REQ-009 comp_len  input  CNT_W  cycles per conversion bit; 0 treated as 1.
REQ-010 p_en_cfg  input  1  requested p-side switch enable for the next sequence.
REQ-011 n_en_cfg  input  1  requested n-side switch enable for the next sequence.
REQ-012 seq_samp  output  1  sampling-phase timing signal driven to the switch control.
REQ-013 samp_p_en  output  1  latched p-side enable; valid while busy.
REQ-014 samp_n_en  output  1  latched n-side enable; valid while busy.
REQ-015 seq_comp  output  1  comparator strobe, high on the first cycle of each bit cycle.
REQ-016 bit_idx  output  clog2(NBITS)  current bit under conversion, MSB first.
REQ-017 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-018 done  output  1  one-cycle pulse at normal sequence completion.
REQ-019 err  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-020 The FSM SHALL have states IDLE, SAMP, HOLD, CONV and DONE.
REQ-021 In IDLE, start=1 SHALL latch samp_len, hold_len, comp_len, p_en_cfg and n_en_cfg and enter SAMP on the next edge.
- Mid-sequence input changes have no effect.
REQ-022 In SAMP, seq_samp SHALL be 1 for exactly max(samp_len,1) cycles, then the FSM enters HOLD.
- If latched hold_len=0, it enters CONV instead.
REQ-023 In HOLD, all seq outputs SHALL be 0 for exactly hold_len cycles, then the FSM enters CONV.
REQ-024 In CONV, the block SHALL run NBITS bit cycles of max(comp_len,1) cycles each.
- bit_idx counts NBITS-1 down to 0.
- seq_comp is high only on the first cycle of each bit cycle; with comp_len<=1, seq_comp stays high for the whole of CONV.
REQ-025 After the bit cycle with bit_idx=0, the FSM SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-026 Latency SHALL be: start at cycle T gives seq_samp high on T+1..T+S, and done at T+1+S+H+NBITS*C.
- S=max(samp_len,1), H=hold_len, C=max(comp_len,1).
REQ-027 samp_p_en and samp_n_en SHALL equal the latched config in SAMP, HOLD, CONV and DONE, and be 0 in IDLE.
REQ-028 start while busy SHALL be ignored and SHALL pulse err for one cycle; the sequence continues unchanged.
- Start in the DONE cycle counts as busy.
REQ-029 abort SHALL override all other inputs: next edge goes to IDLE, all outputs 0, and done is not pulsed.
- Simultaneous start and abort in IDLE means the start is ignored.
REQ-030 The phase counter SHALL saturate and never wrap.
- All-ones length values yield 2^CNT_W-1 cycles.
REQ-031 bit_idx SHALL be 0 outside CONV.

Reset
REQ-032 rst=1 SHALL force IDLE and all outputs to 0 on the next edge, including mid-sequence; rst has priority over abort and start.
REQ-033 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-034 samp_len=4, hold_len=2, comp_len=3, NBITS=8, start at T -> seq_samp high T+1..T+4, first seq_comp at T+7, bit_idx 7..0, done at T+31.
REQ-035 samp_len=0, hold_len=0, comp_len=0 -> seq_samp high for 1 cycle, CONV starts at T+2, seq_comp high 8 consecutive cycles, done at T+10.
REQ-036 p_en_cfg=1, n_en_cfg=0, then cfg flipped mid-sequence -> samp_p_en=1 and samp_n_en=0 throughout; both 0 after DONE.
REQ-037 start pulsed during CONV -> err pulses once; bit_idx and done timing unchanged.
REQ-038 abort during HOLD -> next cycle IDLE, busy=0, no done; a subsequent start runs the full sequence.
REQ-039 rst asserted during CONV (bit_idx=4) -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/samp_seq.sv
// samp_seq -- sample/convert sequencer for a SAR-style front end.
//
// A start request latches the timing lengths and switch enables, then runs:
//   SAMP : seq_samp high for max(samp_len,1) cycles
//   HOLD : all strobes low for hold_len cycles (skipped when hold_len = 0)
//   CONV : NBITS bit cycles of max(comp_len,1) cycles each, MSB first;
//          seq_comp marks the first cycle of every bit cycle
//   DONE : one-cycle done pulse, then back to IDLE
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : sequence request / immediate termination
//   samp_len, hold_len,
//   comp_len            : phase lengths in cycles (CNT_W bits)
//   p_en_cfg, n_en_cfg  : switch enables requested for the next sequence
//   seq_samp, seq_comp  : sampling gate / comparator strobe
//   samp_p_en, samp_n_en: latched switch enables, 0 when idle
//   bit_idx             : bit under conversion, 0 outside CONV
//   busy, done, err     : sequence active / completion pulse / start-while-busy pulse
module samp_seq #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NBITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           samp_len,
  input  logic [CNT_W-1:0]           hold_len,
  input  logic [CNT_W-1:0]           comp_len,
  input  logic                       p_en_cfg,
  input  logic                       n_en_cfg,
  output logic                       seq_samp,
  output logic                       samp_p_en,
  output logic                       samp_n_en,
  output logic                       seq_comp,
  output logic [$clog2(NBITS)-1:0]   bit_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned BW = $clog2(NBITS);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    BIT_ONE = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    BIT_TOP = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SAMP = 3'd1,
    HOLD = 3'd2,
    CONV = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;     // cycles remaining in the current phase/bit, minus one
  logic [BW-1:0]    bit_r, bit_nx;
  logic [CNT_W-1:0] h_len;           // latched hold length
  logic [CNT_W-1:0] c_m1;            // latched max(comp_len,1)-1
  logic             p_lat, n_lat;
  logic             err_r;
  logic             accept;

  assign accept = (state == IDLE) && start && !abort;

  // Next-state and counter logic. The counter is loaded with length-1 on
  // phase entry and only decremented while non-zero, so it can never wrap;
  // an all-ones length therefore gives exactly 2^CNT_W-1 cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_r;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SAMP;
          cnt_nx   = (samp_len == '0) ? '0 : samp_len - CNT_ONE;
        end
      end
      SAMP: begin
        if (cnt == '0) begin
          if (h_len == '0) begin
            state_nx = CONV;
            cnt_nx   = c_m1;
            bit_nx   = BIT_TOP;
          end else begin
            state_nx = HOLD;
            cnt_nx   = h_len - CNT_ONE;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = CONV;
          cnt_nx   = c_m1;
          bit_nx   = BIT_TOP;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      CONV: begin
        if (cnt == '0) begin
          if (bit_r == '0) begin
            state_nx = DONE;
          end else begin
            bit_nx = bit_r - BIT_ONE;
            cnt_nx = c_m1;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        bit_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        bit_nx   = '0;
      end
    endcase
    if (abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      bit_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bit_r <= '0;
      h_len <= '0;
      c_m1  <= '0;
      p_lat <= 1'b0;
      n_lat <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bit_r <= bit_nx;
      err_r <= start && !abort && (state != IDLE);
      if (accept) begin
        h_len <= hold_len;
        c_m1  <= (comp_len == '0) ? '0 : comp_len - CNT_ONE;
        p_lat <= p_en_cfg;
        n_lat <= n_en_cfg;
      end
    end
  end

  // Outputs decode directly from registered state, so reset/abort clear
  // them on the same edge that returns the FSM to IDLE.
  always_comb begin
    busy      = (state != IDLE);
    seq_samp  = (state == SAMP);
    seq_comp  = (state == CONV) && (cnt == c_m1);
    bit_idx   = (state == CONV) ? bit_r : '0;
    done      = (state == DONE);
    samp_p_en = busy && p_lat;
    samp_n_en = busy && n_lat;
    err       = err_r;
  end

endmodule

// File: tb/tb_samp_seq.sv
module tb_samp_seq;

  localparam int NB = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [CW-1:0] samp_len, hold_len, comp_len;
  logic          p_en_cfg, n_en_cfg;
  logic          seq_samp, samp_p_en, samp_n_en, seq_comp, busy, done, err;
  logic [2:0]    bit_idx;
  logic [9:0]    dut_vec;

  samp_seq #(.CNT_W(CW), .NBITS(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .samp_len(samp_len), .hold_len(hold_len), .comp_len(comp_len),
    .p_en_cfg(p_en_cfg), .n_en_cfg(n_en_cfg),
    .seq_samp(seq_samp), .samp_p_en(samp_p_en), .samp_n_en(samp_n_en),
    .seq_comp(seq_comp), .bit_idx(bit_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign dut_vec = {busy, seq_samp, seq_comp, samp_p_en, samp_n_en, done, err, bit_idx};

  int cmp_n  = 0;
  int fail_n = 0;
  int cyc_n  = 0;

  // Reference model: elapsed cycles since the accepted start plus latched config.
  bit m_busy = 0, m_err = 0, m_p = 0, m_n = 0;
  int m_k = 0, m_s = 1, m_h = 0, m_c = 1;

  function automatic logic [9:0] model_vec();
    logic sp, cp, dn;
    logic [2:0] bi;
    int j;
    sp = 0; cp = 0; dn = 0; bi = 0;
    if (m_busy) begin
      if (m_k <= m_s) sp = 1;
      else if (m_k <= m_s + m_h) sp = 0;
      else if (m_k <= m_s + m_h + NB * m_c) begin
        j  = m_k - m_s - m_h - 1;
        cp = (j % m_c == 0);
        bi = 3'(NB - 1 - j / m_c);
      end else dn = 1;
    end
    return {m_busy, sp, cp, m_busy & m_p, m_busy & m_n, dn, m_err, bi};
  endfunction

  task automatic step();
    bit was_busy;
    @(posedge clk);
    was_busy = m_busy;
    if (rst || abort) begin
      m_busy = 0;
      m_err  = 0;
    end else begin
      m_err = start && was_busy;
      if (was_busy) begin
        m_k++;
        if (m_k > m_s + m_h + NB * m_c + 1) m_busy = 0;
      end else if (start) begin
        m_s = (samp_len == 0) ? 1 : int'(samp_len);
        m_h = int'(hold_len);
        m_c = (comp_len == 0) ? 1 : int'(comp_len);
        m_p = p_en_cfg;
        m_n = n_en_cfg;
        m_busy = 1;
        m_k = 1;
      end
    end
    cyc_n++;
    #1;
  endtask

  task automatic cyc(input bit st, input bit ab, input bit r);
    start = st; abort = ab; rst = r;
    step();
  endtask

  task automatic set_cfg(input int s, input int h, input int c, input bit p, input bit n);
    samp_len = CW'(s); hold_len = CW'(h); comp_len = CW'(c);
    p_en_cfg = p; n_en_cfg = n;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      if (dut_vec !== 10'b0) begin
        fail_n++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc_n, dut_vec, 10'b0);
      end
      cmp_n++;
    end
    cyc(1, 1, 1);
    if (dut_vec !== 10'b0) begin
      fail_n++;
      $display("FAIL reset_priority cyc=%0d got=%b exp=%b", cyc_n, dut_vec, 10'b0);
    end
    cmp_n++;
    cyc(0, 0, 0);
    if (dut_vec !== model_vec()) begin
      fail_n++;
      $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc_n, dut_vec, model_vec());
    end
    cmp_n++;
  endtask

  task automatic test_timing(input int s, input int h, input int c, input int exp_last_s,
                             input int exp_first_c, input int exp_ncomp, input int exp_done,
                             input int tmax, input string nm);
    int first_s, last_s, first_c, ncomp, done_t;
    first_s = -1; last_s = -1; first_c = -1; ncomp = 0; done_t = -1;
    set_cfg(s, h, c, 1, 1);
    for (int t = 1; t <= tmax; t++) begin
      cyc(t == 1, 0, 0);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL %s_vec t=%0d got=%b exp=%b", nm, t, dut_vec, model_vec());
      end
      cmp_n++;
      if (seq_samp) begin
        if (first_s < 0) first_s = t;
        last_s = t;
      end
      if (seq_comp) begin
        if (first_c < 0) first_c = t;
        ncomp++;
      end
      if (done) done_t = t;
    end
    if (first_s !== 1 || last_s !== exp_last_s) begin
      fail_n++;
      $display("FAIL %s_samp_window got=%0d..%0d exp=1..%0d", nm, first_s, last_s, exp_last_s);
    end
    cmp_n++;
    if (first_c !== exp_first_c) begin
      fail_n++;
      $display("FAIL %s_first_comp got=%0d exp=%0d", nm, first_c, exp_first_c);
    end
    cmp_n++;
    if (ncomp !== exp_ncomp) begin
      fail_n++;
      $display("FAIL %s_comp_count got=%0d exp=%0d", nm, ncomp, exp_ncomp);
    end
    cmp_n++;
    if (done_t !== exp_done) begin
      fail_n++;
      $display("FAIL %s_done_time got=%0d exp=%0d", nm, done_t, exp_done);
    end
    cmp_n++;
  endtask

  task automatic test_cfg_latch();
    set_cfg(3, 1, 2, 1, 0);
    for (int t = 1; t <= 30; t++) begin
      cyc(t == 1, 0, 0);
      if (t == 3) set_cfg(6, 5, 4, 0, 1);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL cfg_latch_vec t=%0d got=%b exp=%b", t, dut_vec, model_vec());
      end
      cmp_n++;
      if (busy && (samp_p_en !== 1'b1 || samp_n_en !== 1'b0)) begin
        fail_n++;
        $display("FAIL cfg_latch_en t=%0d got=%b%b exp=10", t, samp_p_en, samp_n_en);
      end
      cmp_n++;
    end
    if ({samp_p_en, samp_n_en} !== 2'b00) begin
      fail_n++;
      $display("FAIL cfg_after_done got=%b%b exp=00", samp_p_en, samp_n_en);
    end
    cmp_n++;
  endtask

  task automatic test_err();
    int nerr, done_t;
    nerr = 0; done_t = -1;
    set_cfg(2, 1, 2, 0, 1);
    for (int t = 1; t <= 30; t++) begin
      cyc(t == 1 || t == 9 || t == 21, 0, 0);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL err_vec t=%0d got=%b exp=%b", t, dut_vec, model_vec());
      end
      cmp_n++;
      if (err) nerr++;
      if (done) done_t = t;
    end
    if (nerr !== 2) begin
      fail_n++;
      $display("FAIL err_pulse_count got=%0d exp=2", nerr);
    end
    cmp_n++;
    if (done_t !== 20) begin
      fail_n++;
      $display("FAIL err_done_time got=%0d exp=20", done_t);
    end
    cmp_n++;
  endtask

  task automatic test_abort();
    int ndone, done_t;
    ndone = 0; done_t = -1;
    set_cfg(2, 3, 1, 1, 1);
    for (int t = 1; t <= 30; t++) begin
      cyc(t == 1, t == 4, 0);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL abort_vec t=%0d got=%b exp=%b", t, dut_vec, model_vec());
      end
      cmp_n++;
      if (t == 4 && busy !== 1'b0) begin
        fail_n++;
        $display("FAIL abort_busy got=%b exp=0", busy);
      end
      if (t == 4) cmp_n++;
      if (done) ndone++;
    end
    if (ndone !== 0) begin
      fail_n++;
      $display("FAIL abort_no_done got=%0d exp=0", ndone);
    end
    cmp_n++;
    cyc(1, 1, 0);
    if (busy !== 1'b0) begin
      fail_n++;
      $display("FAIL start_with_abort got=%b exp=0", busy);
    end
    cmp_n++;
    for (int t = 1; t <= 20; t++) begin
      cyc(t == 1, 0, 0);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL abort_rerun_vec t=%0d got=%b exp=%b", t, dut_vec, model_vec());
      end
      cmp_n++;
      if (done) done_t = t;
    end
    if (done_t !== 14) begin
      fail_n++;
      $display("FAIL abort_rerun_done got=%0d exp=14", done_t);
    end
    cmp_n++;
  endtask

  task automatic test_rst_mid();
    int t, done_t;
    t = 0; done_t = -1;
    set_cfg(1, 0, 2, 1, 1);
    cyc(1, 0, 0);
    while (bit_idx !== 3'd4 && t < 30) begin
      cyc(0, 0, 0);
      t++;
    end
    if (bit_idx !== 3'd4) begin
      fail_n++;
      $display("FAIL rst_mid_reach got=%0d exp=4", bit_idx);
    end
    cmp_n++;
    cyc(1, 1, 1);
    if (dut_vec !== 10'b0) begin
      fail_n++;
      $display("FAIL rst_mid_outputs got=%b exp=%b", dut_vec, 10'b0);
    end
    cmp_n++;
    for (int k = 1; k <= 20; k++) begin
      cyc(k == 1, 0, 0);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL rst_rerun_vec t=%0d got=%b exp=%b", k, dut_vec, model_vec());
      end
      cmp_n++;
      if (done) done_t = k;
    end
    if (done_t !== 18) begin
      fail_n++;
      $display("FAIL rst_rerun_done got=%0d exp=18", done_t);
    end
    cmp_n++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3),
              1'($urandom), 1'($urandom));
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0);
      if (dut_vec !== model_vec()) begin
        fail_n++;
        $display("FAIL random_vec cyc=%0d got=%b exp=%b", cyc_n, dut_vec, model_vec());
      end
      cmp_n++;
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0;
    set_cfg(0, 0, 0, 0, 0);
    test_reset();
    test_timing(4, 2, 3, 4, 7, 8, 31, 40, "basic");
    test_timing(0, 0, 0, 1, 2, 8, 10, 16, "zero_len");
    test_cfg_latch();
    test_err();
    test_abort();
    test_rst_mid();
    test_timing(255, 255, 255, 255, 511, 8, 2551, 2560, "saturate");
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
